// File: rtl/instr_fetch_if.sv
// Fetch-stage bus bundle: instruction-memory request/response, redirect input
// and the valid/ready handshake towards decode.
interface instr_fetch_if #(
    parameter int ADDR_W  = 16,
    parameter int INSTR_W = 32
);
    logic               imem_en;
    logic [ADDR_W-1:0]  imem_addr;
    logic [INSTR_W-1:0] imem_rdata;
    logic               redirect_valid;
    logic [ADDR_W-1:0]  redirect_pc;
    logic               dec_valid;
    logic               dec_ready;
    logic [INSTR_W-1:0] dec_instr;
    logic [ADDR_W-1:0]  dec_pc;

    modport master (
        output imem_en,
        output imem_addr,
        input  imem_rdata,
        input  redirect_valid,
        input  redirect_pc,
        output dec_valid,
        input  dec_ready,
        output dec_instr,
        output dec_pc
    );

    modport slave (
        input  imem_en,
        input  imem_addr,
        output imem_rdata,
        output redirect_valid,
        output redirect_pc,
        input  dec_valid,
        output dec_ready,
        input  dec_instr,
        input  dec_pc
    );
endinterface

// File: rtl/instr_fetch.sv
// Instruction fetch stage: PC, synchronous imem requests, in-order instruction FIFO to decode.
// Optional HALT-opcode detection is built when FETCH_HALT_DETECT_EN is defined.
module instr_fetch #(
    parameter int                ADDR_W    = 16,
    parameter int                INSTR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC  = '0,
    parameter int                BUF_DEPTH = 2
) (
    input  logic          clk,
    input  logic          rst,
    instr_fetch_if.master bus
`ifdef FETCH_HALT_DETECT_EN
    ,
    output logic          halted
`endif
);
    localparam int               PTR_W    = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
    localparam int               OCC_W    = $clog2(BUF_DEPTH + 2) + 1;
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(BUF_DEPTH - 1);
    localparam logic [OCC_W-1:0] DEPTH_C  = OCC_W'(BUF_DEPTH);

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        logic [PTR_W-1:0] n;
        if (p == LAST_PTR) begin
            n = '0;
        end else begin
            n = p + PTR_W'(1);
        end
        return n;
    endfunction

    logic [ADDR_W-1:0]  pc_r;
    logic [ADDR_W-1:0]  inflight_pc_r;
    logic               inflight_r;
    logic               halted_r;
    logic [OCC_W-1:0]   count_r;
    logic [PTR_W-1:0]   head_r;
    logic [PTR_W-1:0]   tail_r;
    logic [INSTR_W-1:0] buf_instr_r [BUF_DEPTH];
    logic [ADDR_W-1:0]  buf_pc_r    [BUF_DEPTH];

    logic               dec_valid_s;
    logic               pop_s;
    logic               push_s;
    logic               req_s;
    logic               halt_hit_s;
    logic [OCC_W-1:0]   occ_s;

    // Per-cycle request / capture / pop decisions; occupancy counts the word still in flight
    always_comb begin
        dec_valid_s = (count_r != '0);
        pop_s       = dec_valid_s && bus.dec_ready;
        occ_s       = count_r + OCC_W'(inflight_r) - OCC_W'(pop_s);
        push_s      = 1'b0;
        req_s       = 1'b0;
        if (rst || bus.redirect_valid) begin
            push_s = 1'b0;
            req_s  = 1'b0;
        end else begin
            push_s = inflight_r && !halted_r;
            req_s  = !halted_r && (occ_s < DEPTH_C);
        end
    end

`ifdef FETCH_HALT_DETECT_EN
    localparam logic [5:0] HALT_OP = 6'b111111;
    assign halt_hit_s = push_s && (bus.imem_rdata[INSTR_W-1 -: 6] == HALT_OP);
    assign halted     = halted_r;
`else
    assign halt_hit_s = 1'b0;
`endif

    // PC, outstanding-request tracking and halt flag
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_r          <= RESET_PC;
            inflight_r    <= 1'b0;
            inflight_pc_r <= '0;
            halted_r      <= 1'b0;
        end else if (bus.redirect_valid) begin
            pc_r       <= bus.redirect_pc;
            inflight_r <= 1'b0;
            halted_r   <= 1'b0;
        end else begin
            inflight_r <= req_s;
            if (req_s) begin
                pc_r          <= pc_r + ADDR_W'(1);
                inflight_pc_r <= pc_r;
            end
            if (halt_hit_s) begin
                halted_r <= 1'b1;
            end
        end
    end

    // Instruction FIFO; a flush drops every buffered word
    always_ff @(posedge clk) begin
        if (rst) begin
            count_r <= '0;
            head_r  <= '0;
            tail_r  <= '0;
            for (int i = 0; i < BUF_DEPTH; i++) begin
                buf_instr_r[i] <= '0;
                buf_pc_r[i]    <= '0;
            end
        end else if (bus.redirect_valid) begin
            count_r <= '0;
            head_r  <= '0;
            tail_r  <= '0;
        end else begin
            if (push_s) begin
                buf_instr_r[tail_r] <= bus.imem_rdata;
                buf_pc_r[tail_r]    <= inflight_pc_r;
                tail_r              <= ptr_inc(tail_r);
            end
            if (pop_s) begin
                head_r <= ptr_inc(head_r);
            end
            count_r <= count_r + OCC_W'(push_s) - OCC_W'(pop_s);
        end
    end

    assign bus.imem_en   = req_s;
    assign bus.imem_addr = pc_r;
    assign bus.dec_valid = dec_valid_s;
    assign bus.dec_instr = buf_instr_r[head_r];
    assign bus.dec_pc    = buf_pc_r[head_r];
endmodule

// File: doc/instr_fetch.md
# instr_fetch

Instruction fetch stage of the 16-bit Harvard processor. Maintains the program counter and issues reads to the synchronous instruction memory. Buffers returned 32-bit instruction words and hands them, with their PC, to the decode stage over a valid/ready handshake. Decode extracts the opcode from bits [31:26]. Taken branches and jumps from later stages redirect the PC and flush everything in flight.

## Interface
- ADDR_W, 16, instruction-memory word-address width; PC width
- INSTR_W, 32, instruction word width
- RESET_PC, 0, PC loaded on reset
- BUF_DEPTH, 2, instruction buffer entries; must be ≥2
- clk  in  1  single clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- imem_en  out  1  read request to instruction memory this cycle
- imem_addr  out  ADDR_W  word address of the request; equals the PC register
- imem_rdata  in  INSTR_W  read data; valid exactly one cycle after imem_en
- redirect_valid  in  1  load a new PC and flush
- redirect_pc  in  ADDR_W  target PC
- dec_valid  out  1  dec_instr and dec_pc are valid
- dec_ready  in  1  decode accepts the word this cycle
- dec_instr  out  INSTR_W  instruction word at the buffer head
- dec_pc  out  ADDR_W  PC of dec_instr
- halted  out  1  present only with FETCH_HALT_DETECT_EN

## Operation
- Word-addressed PC. Each issued request increments PC by 1, wrapping 2^ADDR_W−1 → 0.
- Request condition: `count + inflight − (dec_valid & dec_ready) < BUF_DEPTH`, and no redirect, rst, or halt this cycle.
  - count = buffer occupancy.
  - inflight = 1 if imem_en was high last cycle and not cancelled.
- Response capture: when inflight is set, imem_rdata and its PC are written to the buffer tail at the end of that cycle. The buffer never overflows, guaranteed by the request condition.
- Buffer is a FIFO. dec_valid = (count ≠ 0). Head entry drives dec_instr/dec_pc. A handshake pops it.
- Redirect, in the cycle redirect_valid is high:
  - pc ← redirect_pc;
  - buffer cleared;
  - inflight cancelled, so next cycle's imem_rdata is ignored;
  - imem_en = 0.
  - Fetch resumes at redirect_pc the next cycle.
- Redirect and a decode handshake in the same cycle: the handshake completes (that word counts as consumed), then the flush applies.
- Reset has priority over everything. Reset mid-operation cancels inflight, so a memory response arriving the cycle after rst is discarded.
- Reset values:
  - pc = RESET_PC;
  - count = 0;
  - inflight = 0;
  - imem_en = 0;
  - dec_valid = 0;
  - dec_instr = 0;
  - dec_pc = 0;
  - halted = 0.

## Timing
- Request at cycle N → data captured end of N+1 → dec_valid at N+2. Minimum fetch-to-decode latency is 2 cycles.
- First request is the first cycle after rst deasserts.
- Steady-state throughput is one instruction per cycle while dec_ready is held high.
- dec_ready low: the buffer fills to BUF_DEPTH, counting inflight, then imem_en drops. Words and PCs are delivered in order with no loss or duplication.
- dec_instr/dec_pc must hold stable while dec_valid & !dec_ready.
- Redirect at cycle R: dec_valid = 0 at R+1, first request to redirect_pc at R+1, its word reaches decode at R+3.

## Configuration
- FETCH_HALT_DETECT_EN defined:
  - A captured word with [31:26] = 6'b111111 (HALT) is buffered and delivered normally.
  - From the cycle after capture, the stage stops issuing requests and discards the one outstanding response.
  - halted = 1 until redirect_valid or rst.
  - Redirect clears halted and resumes fetch at redirect_pc.
- FETCH_HALT_DETECT_EN undefined:
  - No halted port.
  - Opcode 6'b111111 is fetched like any other word.

## Test plan
- Reset release, memory returns word = {16'hA5A5, pc}, dec_ready = 1:
  - first request addr 0 at cycle 0;
  - dec_valid at cycle 2 with dec_pc 0;
  - then pcs 1, 2, 3 on consecutive cycles.
- dec_ready held low 10 cycles, then high:
  - imem_en stops after BUF_DEPTH outstanding;
  - delivered pcs stay contiguous with no gaps or repeats.
- redirect_valid with redirect_pc = 16'h0040 while 2 words are buffered:
  - dec_valid = 0 next cycle;
  - the stale response is dropped;
  - next delivered dec_pc = 16'h0040.
- Wrap: RESET_PC = 16'hFFFE, dec_ready = 1:
  - delivered pcs are FFFE, FFFF, 0000, 0001.
- rst asserted for 1 cycle mid-stream with inflight set:
  - the response arriving the next cycle is not captured;
  - fetch restarts at RESET_PC.
- FETCH_HALT_DETECT_EN: HALT word at pc 5:
  - pc 5 delivered, halted = 1, no further deliveries;
  - redirect to 16'h0010 → halted = 0 and delivery resumes at 16'h0010.
